// File: rtl/match_event_logger_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : match_event_logger_pkg
//  Description : Shared defaults and helpers for the match event logger.
//  Revision    : 1.0 - initial release
// ============================================================================
package match_event_logger_pkg;

    // Default timestamp / event counter width
    localparam int c_TS_W_DEFAULT  = 16;

    // Default number of event FIFO entries (power of two, >= 2)
    localparam int c_DEPTH_DEFAULT = 4;

    // Ceiling log2, used to size FIFO address and pointer fields
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_event_logger_evt_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : evt_fifo
//  Description : Single-clock event FIFO. Pointers carry one extra wrap bit
//                so full and empty are told apart by the pointer MSBs.
//                A push into a full FIFO is accepted only when a pop happens
//                on the same edge. Output data reads zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_fifo
    import match_event_logger_pkg::*;
#(
    parameter int WIDTH = c_TS_W_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam logic [c_PW-1:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Clear wins over both operations; a pop frees the slot a full push needs
    assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clr;

    // Pointer update: reset/clear empty the FIFO, otherwise advance on push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because empty masks the output
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/match_event_logger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : match_event_logger
//  Description : Timestamps rising edges of the upstream match flag and
//                queues them in a small FIFO for a ready/valid consumer.
//                Keeps a saturating event count and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_event_logger
    import match_event_logger_pkg::*;
#(
    parameter int TS_W  = c_TS_W_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_in,
    input  logic            clr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [TS_W-1:0] ev_ts,
    output logic [TS_W-1:0] ev_cnt,
    output logic            ovf
);

    localparam logic [TS_W-1:0] c_TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0] c_CNT_MAX = '1;

    logic            r_flag_d;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ev_cnt;
    logic            r_ovf;
    logic            w_event;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;

    // A clear on the same edge suppresses the event entirely
    assign w_event  = flag_in & ~r_flag_d & ~clr;
    assign ev_valid = ~w_empty;
    assign w_pop    = ev_valid & ev_ready & ~clr;

    // Delayed flag follows the input every edge, clear included, so a flag
    // still high after a clear is not seen as a new rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_d <= 1'b0;
        end else begin
            r_flag_d <= flag_in;
        end
    end

    // Free-running timestamp, wraps naturally at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (clr) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + c_TS_ONE;
        end
    end

    // Saturating count of every detected event, dropped ones included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_cnt <= '0;
        end else if (clr) begin
            r_ev_cnt <= '0;
        end else if (w_event && (r_ev_cnt != c_CNT_MAX)) begin
            r_ev_cnt <= r_ev_cnt + c_TS_ONE;
        end
    end

    // Sticky overflow: an event arrived while full and nothing left that edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_event && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    evt_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (clr),
        .i_push  (w_event),
        .i_pop   (w_pop),
        .i_data  (r_ts),
        .o_data  (ev_ts),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign ev_cnt = r_ev_cnt;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: doc/match_event_logger.md
MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

Interface
REQ-001 Parameter: TS_W, default 16, width of timestamp counter and event counter.
REQ-002 Parameter: DEPTH, default 4, event FIFO entries; power of two, >= 2.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: flag_in  input  1  sequence-match flag from the upstream AA-BB-CC detector; a Moore output, registered-state driven.
REQ-006 Port: clr  input  1  synchronous clear of logger state.
REQ-007 Port: ev_valid  output  1  FIFO head holds an event.
REQ-008 Port: ev_ready  input  1  consumer accepts the head event.
REQ-009 Port: ev_ts  output  TS_W  timestamp of the head event.
REQ-010 Port: ev_cnt  output  TS_W  total detected events, saturating.
REQ-011 Port: ovf  output  1  sticky: at least one event dropped because the FIFO was full.

Function
REQ-012 The block SHALL register flag_in into flag_d each cycle.
REQ-013 An event SHALL be detected at an edge where flag_in=1 and flag_d=0; a flag held high for several cycles SHALL yield exactly one event.
REQ-014 Free-running counter ts SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-015 The captured timestamp SHALL be the ts value present in the cycle in which the event is detected, i.e. before that edge's increment.
REQ-016 An event detected at edge N SHALL be written to the FIFO at edge N; ev_valid SHALL be 1 in the cycle after edge N if the FIFO was empty (latency 1).
REQ-017 Handshake: a pop SHALL occur at an edge where ev_valid=1 and ev_ready=1.
REQ-018 ev_ts SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-019 ev_ts SHALL read 0 while ev_valid=0.
REQ-020 Events SHALL be delivered in detection order.
REQ-021 Full with no pop at the event edge: the event SHALL be dropped, ovf SHALL be set, and the FIFO SHALL be unchanged.
REQ-022 Full with a pop at the same edge: the push SHALL be accepted, the occupancy SHALL remain DEPTH, and ovf SHALL be unchanged.
REQ-023 Push and pop at the same edge with a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-024 ev_ready while empty SHALL be ignored.
REQ-025 ev_cnt SHALL increment on every detected event, including dropped events, and SHALL saturate at 2^TS_W-1.
REQ-026 clr=1 at an edge SHALL empty the FIFO and zero ev_cnt, ovf and ts.
REQ-027 clr=1 at an edge SHALL NOT load flag_d with 1: flag_d SHALL load flag_in.
REQ-028 clr has priority: an event coinciding with clr SHALL be neither stored nor counted.
REQ-029 A pop coinciding with clr SHALL be discarded.

Reset
REQ-030 rst_n=0 SHALL asynchronously force flag_d=0, ts=0, FIFO empty, ev_valid=0, ev_ts=0, ev_cnt=0 and ovf=0.
REQ-031 Reset mid-operation SHALL discard all queued events with no partial pop.
REQ-032 After deassertion, a flag_in already high at the first edge SHALL count as a rising edge, because flag_d=0.

Structure
REQ-033 A shared package SHALL hold the defaults of TS_W and DEPTH and the pointer-width function clog2(DEPTH).
REQ-034 The FIFO SHALL be a sub-module, evt_fifo.
REQ-035 evt_fifo SHALL be a synchronous single-clock FIFO: width TS_W, depth DEPTH, pointers of clog2(DEPTH)+1 bits, with full/empty from pointer MSB comparison.
REQ-036 Edge detection, ts, ev_cnt and ovf SHALL reside in the top-level module.

Verification
REQ-037 Single event: after reset, flag_in=1 for one cycle at ts=5, ev_ready=0 -> next cycle ev_valid=1, ev_ts=5, ev_cnt=1; hold 10 cycles, ev_ts stays 5.
REQ-038 Held flag: flag_in=1 for 3 cycles starting at ts=20 -> exactly one event, ev_ts=20, ev_cnt=1.
REQ-039 Overflow: 5 events at ts=10,12,14,16,18 with ev_ready=0 -> ovf=1, ev_cnt=5; draining yields ev_ts 10,12,14,16, then ev_valid=0.
REQ-040 Full plus pop: FIFO full, ev_ready=1, event at the same edge -> ovf stays 0, occupancy stays 4, the new timestamp appears last.
REQ-041 Wrap and saturation: force ts to 0xFFFF and inject an event -> ev_ts=0xFFFF; preload ev_cnt to 0xFFFF and inject an event -> ev_cnt stays 0xFFFF.
REQ-042 Clear and reset: clr coincident with an event while 2 entries are queued -> ev_valid=0, ev_cnt=0, ts=0; rst_n pulse mid-drain -> all outputs 0 immediately.
